// File: rtl/seq_gen.sv
// seq_gen: symbol buffer that replays stored 3-bit symbols onto an analyzer's
// q1/q2/q3 inputs under a valid/ready handshake and pulses c on completion.
//
// Optional feature: define SEQ_GEN_LOOP_EN to replay continuously until stop.
//
// Parameters:
//   DEPTH - buffer entries (power of two, >= 2)
//   AW    - pointer width, log2(DEPTH)
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   wr_en, wr_data   - write one symbol (bit0->q1, bit1->q2, bit2->q3)
//   clr              - empty the buffer
//   start            - begin replay
//   ready            - consumer accepts current symbol
//   stop             - end looping (SEQ_GEN_LOOP_EN only)
//   q1, q2, q3       - current symbol bits, 0 when not valid
//   valid            - a symbol is presented
//   busy             - not idle
//   full             - buffer holds DEPTH symbols
//   count            - number of stored symbols
//   c                - one-cycle completion pulse
module seq_gen #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [2:0]    wr_data,
  input  logic          clr,
  input  logic          start,
  input  logic          ready,
`ifdef SEQ_GEN_LOOP_EN
  input  logic          stop,
`endif
  output logic          q1,
  output logic          q2,
  output logic          q3,
  output logic          valid,
  output logic          busy,
  output logic          full,
  output logic [AW:0]   count,
  output logic          c
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          c_q, c_d;
  logic [2:0]    buf_q [DEPTH];
  logic          last_entry;
  logic          wr_ok;
  logic [2:0]    sym;

`ifdef SEQ_GEN_LOOP_EN
  logic          stop_q, stop_d;
`endif

  assign full       = (count_q == (AW + 1)'(DEPTH));
  assign last_entry = ({1'b0, rd_ptr_q} == (count_q - (AW + 1)'(1)));
  assign wr_ok      = (state_q == StIdle) && !clr && wr_en && !full;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    c_d      = 1'b0;
`ifdef SEQ_GEN_LOOP_EN
    stop_d   = stop_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef SEQ_GEN_LOOP_EN
        stop_d = 1'b0;
`endif
        if (clr) begin
          count_d = '0;
        end else if (wr_ok) begin
          count_d = count_q + (AW + 1)'(1);
        end
        // Start sees the count including a write landing this same cycle.
        if (start && (count_d != '0)) begin
          rd_ptr_d = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
`ifdef SEQ_GEN_LOOP_EN
        stop_d = stop_q | stop;
`endif
        if (ready) begin
          if (last_entry) begin
            // c follows every completed pass, whether or not replay ends.
            c_d      = 1'b1;
            rd_ptr_d = '0;
`ifdef SEQ_GEN_LOOP_EN
            if (stop_q || stop) begin
              state_d = StDone;
            end
`else
            state_d = StDone;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_ptr_q <= '0;
      c_q      <= 1'b0;
`ifdef SEQ_GEN_LOOP_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      c_q      <= c_d;
`ifdef SEQ_GEN_LOOP_EN
      stop_q   <= stop_d;
`endif
    end
  end

  // Buffer RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      buf_q[count_q[AW-1:0]] <= wr_data;
    end
  end

  assign sym          = buf_q[rd_ptr_q];
  assign valid        = (state_q == StSend);
  assign busy         = (state_q != StIdle);
  assign count        = count_q;
  assign c            = c_q;
  assign {q3, q2, q1} = valid ? sym : 3'b000;

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_data;
  logic       clr;
  logic       start;
  logic       ready;
`ifdef SEQ_GEN_LOOP_EN
  logic       stop;
`endif
  logic       q1, q2, q3;
  logic       valid, busy, full, c;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  seq_gen #(.DEPTH(8), .AW(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr     (clr),
    .start   (start),
    .ready   (ready),
`ifdef SEQ_GEN_LOOP_EN
    .stop    (stop),
`endif
    .q1      (q1),
    .q2      (q2),
    .q3      (q3),
    .valid   (valid),
    .busy    (busy),
    .full    (full),
    .count   (count),
    .c       (c)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sym(input logic [2:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({valid, busy, full, c} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {valid, busy, full, c});
    end
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if ({q3, q2, q1} !== 3'b000) begin
      bad++;
      $display("FAIL reset_q got=%b want=000", {q3, q2, q1});
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp [3] = '{3'b101, 3'b010, 3'b111};
    write_sym(3'b101);
    write_sym(3'b010);
    write_sym(3'b111);
    total++;
    if (count !== 4'd3) begin
      bad++;
      $display("FAIL basic_count got=%0d want=3", count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({valid, q3, q2, q1} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL basic_sym%0d got=%b want=%b", i, {valid, q3, q2, q1}, {1'b1, exp[i]});
      end
      tick();
    end
    total++;
    if ({c, valid} !== 2'b10) begin
      bad++;
      $display("FAIL basic_done got c,valid=%b want=10", {c, valid});
    end
    ready = 1'b0;
    tick();
    total++;
    if ({c, busy} !== 2'b00) begin
      bad++;
      $display("FAIL basic_idle got c,busy=%b want=00", {c, busy});
    end
  endtask

  // Replays the retained buffer from test_basic with a stalling consumer.
  task automatic test_ready_stall();
    logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] exp [5] = '{3'b101, 3'b010, 3'b010, 3'b010, 3'b111};
    int xfers = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ready = rdy[i];
      total++;
      if ({valid, q3, q2, q1} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL stall_sym%0d got=%b want=%b", i, {valid, q3, q2, q1}, {1'b1, exp[i]});
      end
      if (valid && ready) xfers++;
      tick();
    end
    ready = 1'b0;
    total++;
    if ({c, valid} !== 2'b10 || xfers != 3) begin
      bad++;
      $display("FAIL stall_done got c,valid=%b xfers=%0d want=10 xfers=3", {c, valid}, xfers);
    end
    tick();
  endtask

  task automatic test_full();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      write_sym(3'(7 - i));
      if (i == 6) begin
        total++;
        if (full !== 1'b0) begin
          bad++;
          $display("FAIL full_after7 got=%b want=0", full);
        end
      end
      if (i == 7) begin
        total++;
        if (full !== 1'b1) begin
          bad++;
          $display("FAIL full_after8 got=%b want=1", full);
        end
      end
    end
    total++;
    if (count !== 4'd8) begin
      bad++;
      $display("FAIL full_count got=%0d want=8", count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({valid, q3, q2, q1} !== {1'b1, 3'(7 - i)}) begin
        bad++;
        $display("FAIL full_sym%0d got=%b want=%b", i, {valid, q3, q2, q1}, {1'b1, 3'(7 - i)});
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if ({c, valid} !== 2'b10) begin
      bad++;
      $display("FAIL full_done got c,valid=%b want=10", {c, valid});
    end
    tick();
  endtask

  task automatic test_empty_start();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL empty_count got=%0d want=0", count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({busy, valid, c} !== 3'b000) begin
        bad++;
        $display("FAIL empty_start%0d got busy,valid,c=%b want=000", i, {busy, valid, c});
      end
      tick();
    end
    ready = 1'b0;
    write_sym(3'b011);
    total++;
    if (count !== 4'd1) begin
      bad++;
      $display("FAIL empty_write got=%0d want=1", count);
    end
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 3'b110;
    tick();
    clr   = 1'b0;
    wr_en = 1'b0;
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL clr_wins got=%0d want=0", count);
    end
  endtask

  task automatic test_reset_mid();
    write_sym(3'b001);
    write_sym(3'b010);
    write_sym(3'b100);
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    total++;
    if ({valid, q3, q2, q1} !== 4'b1100) begin
      bad++;
      $display("FAIL midrst_pre got=%b want=1100", {valid, q3, q2, q1});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({valid, busy, c} !== 3'b000 || count !== 4'd0) begin
      bad++;
      $display("FAIL midrst_post got v,b,c=%b count=%0d want=000 count=0", {valid, busy, c},
               count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({valid, busy, c} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_start got v,b,c=%b want=000", {valid, busy, c});
    end
    tick();
    ready = 1'b0;
    total++;
    if ({valid, busy, c} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_quiet got v,b,c=%b want=000", {valid, busy, c});
    end
  endtask

`ifdef SEQ_GEN_LOOP_EN
  task automatic test_loop();
    int xfers  = 0;
    int pulses = 0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    write_sym(3'b011);
    write_sym(3'b100);
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      // Stop is high only while the first symbol of pass 3 is presented.
      stop = (xfers == 4) && valid;
      if (c) pulses++;
      if (valid && ready) xfers++;
      tick();
    end
    stop  = 1'b0;
    ready = 1'b0;
    total++;
    if (xfers != 6) begin
      bad++;
      $display("FAIL loop_xfers got=%0d want=6", xfers);
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL loop_pulses got=%0d want=3", pulses);
    end
    total++;
    if ({busy, valid} !== 2'b00) begin
      bad++;
      $display("FAIL loop_end got busy,valid=%b want=00", {busy, valid});
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 3'b000;
    clr     = 1'b0;
    start   = 1'b0;
    ready   = 1'b0;
`ifdef SEQ_GEN_LOOP_EN
    stop    = 1'b0;
`endif
    test_reset();
    test_basic();
    test_ready_stall();
    test_full();
    test_empty_start();
    test_reset_mid();
`ifdef SEQ_GEN_LOOP_EN
    test_loop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
